// File: rtl/register_bank_pkg.sv
// Shared types and default sizes for the register bank and its clear controller.
package register_bank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/register_bank_clr_fsm.sv
// Power-up / reset clear sequencer: sweeps every address once with a zero write,
// then holds RUN (Ready high) until the next reset.
module register_bank_clr_fsm
  import register_bank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  output logic              o_ready,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_clr_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_ADDR) begin
        r_state <= ST_RUN;
      end
    end
  end

  // Gating with reset keeps the first zero write on the edge after release.
  assign o_clr_we   = (r_state == ST_CLEAR) && !reset;
  assign o_clr_addr = r_cnt;
  assign o_ready    = (r_state == ST_RUN);

endmodule

// File: rtl/register_bank.sv
// Two-read / one-write register file with a self-clearing sequence after reset.
// Define REGISTER_BANK_BYPASS_EN to forward same-cycle write data to the read ports.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Read1,
  input  logic [ADDR_W-1:0] Read2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic              Ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_we;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  register_bank_clr_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clr_fsm (
    .clock     (clock),
    .reset     (reset),
    .o_ready   (Ready),
    .o_clr_addr(w_clr_addr),
    .o_clr_we  (w_clr_we)
  );

  assign w_wr_en = Ready && RegWrite && !(ZERO_REG && (WriteReg == '0));

  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_rf[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_rf[WriteReg] <= WriteData;
    end
  end

  assign w_raddr[0] = Read1;
  assign w_raddr[1] = Read2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic w_zero;
      logic w_fwd;
      assign w_zero = ZERO_REG && (w_raddr[gi] == '0);
`ifdef REGISTER_BANK_BYPASS_EN
      // w_wr_en already excludes the suppressed zero register and the clear phase.
      assign w_fwd = w_wr_en && (WriteReg == w_raddr[gi]);
`else
      assign w_fwd = 1'b0;
`endif
      assign w_rdata[gi] = (!Ready || w_zero) ? '0 :
                           w_fwd              ? WriteData :
                                                r_rf[w_raddr[gi]];
    end
  endgenerate

  assign Data1 = w_rdata[0];
  assign Data2 = w_rdata[1];

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus random traffic
// against a behavioural model (clear countdown + plain memory array).
module tb_register_bank;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
`ifdef REGISTER_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] Read1 = '0, Read2 = '0, WriteReg = '0;
  logic [DW-1:0] WriteData = '0;
  logic          RegWrite = 1'b0;
  logic [DW-1:0] Data1, Data2, Data1_nz, Data2_nz;
  logic          Ready, Ready_nz;

  always #5 clock = ~clock;

  register_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut (
    .clock(clock), .reset(reset), .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Data1(Data1), .Data2(Data2), .Ready(Ready)
  );

  register_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut_nz (
    .clock(clock), .reset(reset), .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Data1(Data1_nz), .Data2(Data2_nz), .Ready(Ready_nz)
  );

  // Model: after a reset the bank is all-zero and unusable for DEPTH cycles.
  logic [DW-1:0] m_rf    [DEPTH];
  logic [DW-1:0] m_rf_nz [DEPTH];
  int clr_left = DEPTH;
  int total = 0;
  int bad   = 0;

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit zr);
    if (clr_left != 0) return '0;
    if (zr && a == 0) return '0;
    if (BYP && RegWrite && WriteReg == a) return WriteData;
    return zr ? m_rf[a] : m_rf_nz[a];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample(input string tag);
    #1;
    chk({tag, ".ready"}, {31'd0, Ready}, {31'd0, clr_left == 0});
    chk({tag, ".d1"}, Data1, exp_read(Read1, 1'b1));
    chk({tag, ".d2"}, Data2, exp_read(Read2, 1'b1));
    $display("txn %-10s rst=%0d we=%0d wa=%0d wd=%h r1=%0d d1=%h r2=%0d d2=%h rdy=%0d",
             tag, reset, RegWrite, WriteReg, WriteData, Read1, Data1, Read2, Data2, Ready);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m_rf[i] = '0;
        m_rf_nz[i] = '0;
      end
    end else if (clr_left > 0) begin
      clr_left--;
    end else if (RegWrite) begin
      m_rf_nz[WriteReg] = WriteData;
      if (WriteReg != 0) m_rf[WriteReg] = WriteData;
    end
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
  endtask

  initial begin
    // Reset held two cycles.
    reset = 1'b1;
    tick(); tick();
    sample("reset");
    chk("reset.d1_zero", Data1, '0);
    reset = 1'b0;

    // Clear phase with junk writes that must be ignored.
    for (int c = 0; c < DEPTH; c++) begin
      Read1 = 5'($urandom_range(0, 31)); Read2 = 5'($urandom_range(0, 31));
      RegWrite = 1'b1; WriteReg = 5'($urandom_range(0, 31)); WriteData = $urandom;
      sample("clear");
      tick();
    end
    idle_inputs();
    sample("ready_up");
    chk("ready_rise", {31'd0, Ready}, 32'd1);
    for (int a = 0; a < DEPTH; a++) begin
      Read1 = 5'(a); Read2 = 5'(DEPTH - 1 - a);
      sample("zeroed");
      chk("zeroed.d1", Data1, '0);
    end

    // Write 17 then read on both ports.
    RegWrite = 1'b1; WriteReg = 5'd17; WriteData = 32'h3;
    tick();
    idle_inputs(); Read1 = 5'd17; Read2 = 5'd17;
    sample("rd17");
    chk("rd17.d1", Data1, 32'h3);
    chk("rd17.d2", Data2, 32'h3);

    // Zero register behaviour on both builds of ZERO_REG.
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'hFFFF_FFFF;
    tick();
    idle_inputs(); Read1 = 5'd0; Read2 = 5'd0;
    sample("rd0");
    chk("rd0.zr1", Data1, 32'h0);
    chk("rd0.zr0", Data1_nz, 32'hFFFF_FFFF);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      RegWrite  = 1'($urandom_range(0, 1));
      WriteReg  = 5'($urandom_range(0, 31));
      WriteData = $urandom;
      Read1     = ($urandom_range(0, 3) == 0) ? WriteReg : 5'($urandom_range(0, 31));
      Read2     = ($urandom_range(0, 3) == 0) ? Read1 : 5'($urandom_range(0, 31));
      sample("rand");
      if (Read1 == Read2) chk("rand.same", Data2, Data1);
      tick();
    end
    idle_inputs();

    // Reset in RUN, then reset again at clear cycle 10.
    RegWrite = 1'b1; WriteReg = 5'd18; WriteData = 32'h2;
    tick();
    idle_inputs();
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      sample("clr_a");
      tick();
    end
    reset = 1'b1; tick(); reset = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      if (c == 3) begin
        RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hA;
      end else begin
        idle_inputs();
      end
      Read1 = 5'd18; Read2 = 5'd5;
      sample("clr_b");
      chk("clr_b.rdy_low", {31'd0, Ready}, 32'd0);
      tick();
    end
    idle_inputs(); Read1 = 5'd18; Read2 = 5'd5;
    sample("after_rst");
    chk("after_rst.rdy", {31'd0, Ready}, 32'd1);
    chk("after_rst.r18", Data1, 32'h0);
    chk("after_rst.r5", Data2, 32'h0);

    // Same-cycle write and read of register 9.
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h11;
    tick();
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h55; Read1 = 5'd9; Read2 = 5'd9;
    sample("byp");
    chk("byp.same_cycle", Data1, BYP ? 32'h55 : 32'h11);
    tick();
    idle_inputs();
    sample("byp_next");
    chk("byp.next_cycle", Data1, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have parameter ZERO_REG, default 1, where 1 makes register 0 read as zero and ignore writes.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have ports Read1 and Read2, input, ADDR_W each, read addresses.
REQ-007 SHALL have port WriteReg, input, ADDR_W, write address.
REQ-008 SHALL have port WriteData, input, DATA_W, write data.
REQ-009 SHALL have port RegWrite, input, 1, write enable.
REQ-010 SHALL have ports Data1 and Data2, output, DATA_W each, read data.
REQ-011 SHALL have port Ready, output, 1, high when the bank accepts writes and returns valid reads.

Function
REQ-012 SHALL implement a two-state FSM, CLEAR and RUN, with an ADDR_W-bit clear counter.
REQ-013 In CLEAR, SHALL write zero to RF[counter] each cycle and increment the counter.
REQ-014 In CLEAR, SHALL move to RUN on the edge where counter == DEPTH-1; full clear takes DEPTH cycles.
REQ-015 In RUN, SHALL remain in RUN until reset.
REQ-016 Ready SHALL be high exactly when the state is RUN.
REQ-017 When Ready is low, RegWrite SHALL be ignored and Data1/Data2 SHALL be driven to 0.
REQ-018 In RUN, if RegWrite is high, SHALL write RF[WriteReg] <= WriteData at the rising edge.
REQ-019 Reads SHALL be combinational, zero latency: DataN = RF[ReadN].
REQ-020 If ZERO_REG=1: writes to address 0 SHALL be dropped, and reads of address 0 SHALL return 0.
REQ-021 Read1 == Read2 SHALL return identical data on both ports.

Reset
REQ-022 While reset is high: state SHALL be CLEAR, counter 0, Ready 0, Data1/Data2 0.
REQ-023 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-024 Reset asserted in RUN SHALL start a full clear from address 0.
REQ-025 The first clear write (address 0) SHALL occur on the first edge after reset deasserts.

Configuration
REQ-026 Macro REGISTER_BANK_BYPASS_EN SHALL control write-to-read forwarding.
REQ-027 When REGISTER_BANK_BYPASS_EN is defined, a read SHALL forward WriteData in the same cycle when all of these hold: Ready=1, RegWrite=1, WriteReg == ReadN, and the address is not a suppressed zero register.
REQ-028 When REGISTER_BANK_BYPASS_EN is undefined, DataN SHALL show the old value until the cycle after the write edge.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (CLEAR, RUN) and the default DATA_W/ADDR_W constants.
REQ-030 The design SHALL use one sub-module, register_bank_clr_fsm, which owns the state, the counter and Ready, and supplies the clear address and clear write-enable to the storage array.

Verification
REQ-031 Clear timing: reset high 2 cycles, then low -> Ready = 0 for exactly 32 cycles, then 1; every Read of 0..31 returns 0.
REQ-032 Write then read: in RUN, write WriteReg=17, WriteData=32'h3 -> next cycle Read1=17 gives Data1=32'h3; Read2=17 gives Data2=32'h3.
REQ-033 Zero register: in RUN, write WriteReg=0, WriteData=32'hFFFF_FFFF -> Read1=0 gives Data1=0 (ZERO_REG=1); with ZERO_REG=0, Data1=32'hFFFF_FFFF.
REQ-034 Reset mid-clear: assert reset at clear cycle 10 for 1 cycle -> Ready low a further 32 cycles from release; earlier RUN data at reg 18 (32'h2) reads 0.
REQ-035 Write during CLEAR: RegWrite=1, WriteReg=5, WriteData=32'hA at clear cycle 3 -> after Ready rises, Read1=5 gives 0.
REQ-036 Same-cycle write and read: RegWrite=1, WriteReg=Read1=9, WriteData=32'h55, old value 32'h11 -> Data1=32'h55 that cycle with REGISTER_BANK_BYPASS_EN defined, 32'h11 without it; 32'h55 in both builds the next cycle.
